bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Sequential front end for the calculator's six HEX displays. Accepts a binary result over a valid/ready handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) sequencer, one bit per cycle. It then latches the digits and drives six active-low 7-segment outputs. It replaces per-digit divide/modulo logic with a small, timed datapath, and holds the displayed value stable between updates.

## Interface
- `WIDTH`, default 8: binary input width. Legal range 1..19, so the maximum 999999 fits in six digits. Elaborate-time error outside this range.
- `clk` input, 1 bit: sole clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: block can accept a value.
- `in_data` input, WIDTH bits: unsigned binary value to display.
- `done` output, 1 bit: one-cycle pulse when the displays update.
- `ho0`..`ho5` output, 7 bits each: active-low segments `{g,f,e,d,c,b,a}`. `ho0` is the ones digit; `ho5` is the hundred-thousands digit.

## Operation
- FSM states: IDLE, CONV, DONE.
  - IDLE: `in_ready`=1. On `in_valid`&`in_ready` at an edge, load the shift register with `in_data`, clear the BCD accumulator (24 bits), load the bit counter with WIDTH, and go to CONV.
  - CONV: each cycle, add 3 to every BCD nibble ≥5, then shift `{bcd, bin}` left by 1 and decrement the counter. After the WIDTH-th shift, go to DONE.
  - DONE: register the six nibbles into the display registers, assert `done` for this cycle only, and return to IDLE.
- `in_valid` outside IDLE is ignored. No queueing.
- Display registers change only in DONE or on reset. `ho*` are registered, not combinational from the accumulator.
- Digit encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank=1111111. A nibble >9 cannot occur; if one does, the digit is driven blank.
- Arithmetic: all BCD nibble adds are 4-bit. The add-3 correction is applied before the shift, never after the final shift.

## Timing
- Reset values: all `ho*`=7'b1111111 (blank), `in_ready`=1, `done`=0, state IDLE, accumulator 0.
- Latency: handshake at edge N → CONV during cycles N+1..N+WIDTH → DONE state in cycle N+WIDTH+1. `done` is high and the new `ho*` are visible from edge N+WIDTH+1.
- Throughput: one value per WIDTH+2 cycles. `in_ready` is low in CONV and DONE. The next accept is possible at edge N+WIDTH+2.
- Reset mid-CONV or in DONE: conversion is aborted and no `done` is issued. Displays go blank and the block is in IDLE on the following cycle.
- Reset together with `in_valid`: reset wins, and the value is discarded.

## Configuration
- `BCD_DISPLAY_LEAD_ZERO_BLANK_EN` defined: digits above the most significant nonzero digit are driven blank. `ho0` always shows a digit, so a value of 0 shows "0".
- Not defined: all six digits are shown, including leading zeros.
- The feature is applied in DONE when the display registers are loaded. Latency is unchanged either way.

## Structure
- Package `bcd_display_pkg` holds:
  - the state enum;
  - `SEG_BLANK`;
  - the ten digit segment constants;
  - `NUM_DIGITS`=6;
  - the `WIDTH` maximum constant 19.
- Sub-module `bcd_seg_encode`: combinational, 4-bit nibble plus blank flag → 7-bit active-low segments. Instantiated six times at the display-register inputs.

## Test plan
- Reset: assert `reset` for 2 cycles → all `ho*`=1111111, `in_ready`=1, `done`=0.
- WIDTH=8, `in_data`=8'd255 → `done` exactly 9 cycles after accept. `ho2`=0100100, `ho1`=0010010, `ho0`=0010010. `ho3..5` are blank with the macro defined, and 1000000 without it.
- `in_data`=8'd0 → `ho0`=1000000. `ho1..5` are blank with the macro defined, and 1000000 without it.
- Accept 8'd42, then drive `in_valid` with 8'd7 during CONV → `in_ready`=0 and 7 is ignored. Displays show 42 (`ho1`=0011001, `ho0`=0100100) with a single `done` pulse.
- Hold `in_valid` high with 8'd42 then 8'd100 → the second value is accepted exactly 10 cycles after the first. Displays go to 42, then 100. There are two `done` pulses, 10 cycles apart.
- Accept 8'd123, assert `reset` in the 4th CONV cycle → no `done` is issued, displays stay blank, and `in_ready`=1 the next cycle. A new value of 8'd9 is then converted normally.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared states, segment constants and sizes for bcd_display_ctrl
package bcd_display_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int WIDTH_MAX  = 19;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_seg_encode.sv
// rtl/bcd_seg_encode.sv - BCD nibble plus blank flag to active-low 7-segment pattern
module bcd_seg_encode
    import bcd_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// rtl/bcd_display_ctrl.sv - double-dabble binary-to-BCD sequencer driving six registered HEX displays
// Optional leading-zero blanking: BCD_DISPLAY_LEAD_ZERO_BLANK_EN
module bcd_display_ctrl
    import bcd_display_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             done,
    output logic [6:0]       ho0,
    output logic [6:0]       ho1,
    output logic [6:0]       ho2,
    output logic [6:0]       ho3,
    output logic [6:0]       ho4,
    output logic [6:0]       ho5
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("bcd_display_ctrl: WIDTH must be in 1..19");
        end
    endgenerate

    state_e                         state_q, state_d;
    logic [WIDTH-1:0]               bin_q, bin_d;
    logic [BCD_W-1:0]               bcd_q, bcd_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           done_q, done_d;
    logic [NUM_DIGITS-1:0][6:0]     ho_q, ho_d;

    logic [BCD_W-1:0]               bcd_adj;
    logic [BCD_W+WIDTH-1:0]         shifted;
    logic [NUM_DIGITS-1:0]          blank;
    logic [NUM_DIGITS-1:0][6:0]     seg;

    // Add-3 correction happens before each shift, so the final shift leaves clean BCD.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                           : bcd_q[4*i +: 4];
        end
    end

    assign shifted = {bcd_adj, bin_q} << 1;

`ifdef BCD_DISPLAY_LEAD_ZERO_BLANK_EN
    logic lead_zero;

    // Ones digit is never blanked so a zero value still shows "0".
    always_comb begin
        blank     = '0;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead_zero = lead_zero && (bcd_q[4*i +: 4] == 4'd0);
            blank[i]  = lead_zero;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        bcd_seg_encode u_enc (
            .nibble (bcd_q[4*g +: 4]),
            .blank  (blank[g]),
            .seg    (seg[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ho_d     = ho_q;
        done_d   = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bin_d   = in_data;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = shifted[BCD_W+WIDTH-1:WIDTH];
                bin_d = shifted[WIDTH-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ho_d    = seg;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ho_q    <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ho_q    <= ho_d;
        end
    end

    assign done = done_q;
    assign ho0  = ho_q[0];
    assign ho1  = ho_q[1];
    assign ho2  = ho_q[2];
    assign ho3  = ho_q[3];
    assign ho4  = ho_q[4];
    assign ho5  = ho_q[5];

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb/tb_bcd_display_ctrl.sv - directed self-checking bench for bcd_display_ctrl
module tb_bcd_display_ctrl;

    localparam int W = 8;

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] D0  = 7'b1000000;
    localparam logic [6:0] D1  = 7'b1111001;
    localparam logic [6:0] D2  = 7'b0100100;
    localparam logic [6:0] D4  = 7'b0011001;
    localparam logic [6:0] D5  = 7'b0010010;
    localparam logic [6:0] D8  = 7'b0000000;
    localparam logic [6:0] D9  = 7'b0010000;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         done;
    logic [6:0]   ho0, ho1, ho2, ho3, ho4, ho5;

    always #5 clk = ~clk;

    bcd_display_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .done     (done),
        .ho0      (ho0),
        .ho1      (ho1),
        .ho2      (ho2),
        .ho3      (ho3),
        .ho4      (ho4),
        .ho5      (ho5)
    );

    typedef struct {
        logic [7:0]      data;
        logic [5:0][6:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Leading digits at or above the value's magnitude are blank when the feature is built in.
    function automatic logic [5:0][6:0] mode_exp(input logic [7:0] v, input logic [5:0][6:0] e);
        logic [5:0][6:0] r;
        int p;
        r = e;
        p = 1;
        for (int i = 1; i < 6; i++) begin
            p = p * 10;
`ifdef BCD_DISPLAY_LEAD_ZERO_BLANK_EN
            if (int'(v) < p) r[i] = BLK;
`endif
        end
        return r;
    endfunction

    task automatic check_ho(input string name, input logic [5:0][6:0] exp);
        logic [5:0][6:0] act;
        act = {ho5, ho4, ho3, ho2, ho1, ho0};
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_ho%0d", name, i), 32'(act[i]), 32'(exp[i]));
        end
    endtask

    task automatic send(input logic [7:0] d, output int lat);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        check("ready_before_accept", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;
        int rdy_err;
        int acc_n, done_n;
        int acc_e[2];
        int done_e[2];
        logic accept_now;
        logic [5:0][6:0] mid_ho;

        vecs[0] = '{8'd255, {D0, D0, D0, D2, D5, D5}};
        vecs[1] = '{8'd0,   {D0, D0, D0, D0, D0, D0}};
        vecs[2] = '{8'd42,  {D0, D0, D0, D0, D4, D2}};
        vecs[3] = '{8'd100, {D0, D0, D0, D1, D0, D0}};
        vecs[4] = '{8'd128, {D0, D0, D0, D1, D2, D8}};
        vecs[5] = '{8'd99,  {D0, D0, D0, D0, D9, D9}};
        vecs[6] = '{8'd9,   {D0, D0, D0, D0, D0, D9}};
        vecs[7] = '{8'd10,  {D0, D0, D0, D0, D1, D0}};

        // Reset with a valid input present: reset wins and the value is dropped.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd55;
        repeat (2) @(negedge clk);
        check_ho("reset", {6{BLK}});
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_discards_valid", 32'(in_ready), 32'd1);
        check("reset_no_done", 32'(done), 32'd0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].data, lat);
            check($sformatf("latency_%0d", vecs[i].data), 32'(lat), 32'd9);
            check_ho($sformatf("value_%0d", vecs[i].data), mode_exp(vecs[i].data, vecs[i].exp));
        end

        // A second value offered during conversion is ignored.
        @(negedge clk);
        in_data  = 8'd42;
        in_valid = 1'b1;
        @(negedge clk);
        in_data  = 8'd7;
        lat      = 0;
        rdy_err  = 0;
        while (!done && lat < 40) begin
            if (in_ready) rdy_err++;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("ignore_latency", 32'(lat), 32'd9);
        check("ignore_ready_low", 32'(rdy_err), 32'd0);
        check_ho("ignore_42", mode_exp(8'd42, {D0, D0, D0, D0, D4, D2}));
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignore_no_extra_done", 32'(ndone), 32'd0);
        check_ho("ignore_still_42", mode_exp(8'd42, {D0, D0, D0, D0, D4, D2}));

        // Back-to-back with in_valid held high.
        in_data  = 8'd42;
        in_valid = 1'b1;
        acc_n    = 0;
        done_n   = 0;
        acc_e    = '{0, 0};
        done_e   = '{0, 0};
        mid_ho   = '0;
        for (int t = 0; t < 40; t++) begin
            accept_now = in_valid && in_ready;
            if (accept_now && acc_n < 2) begin
                acc_e[acc_n] = t + 1;
                acc_n++;
            end
            if (done) begin
                if (done_n < 2) done_e[done_n] = t;
                if (done_n == 0) mid_ho = {ho5, ho4, ho3, ho2, ho1, ho0};
                done_n++;
            end
            if (acc_n == 1 && !accept_now) in_data = 8'd100;
            if (acc_n == 2 && !accept_now) in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_accepts", 32'(acc_n), 32'd2);
        check("b2b_accept_gap", 32'(acc_e[1] - acc_e[0]), 32'd10);
        check("b2b_done_count", 32'(done_n), 32'd2);
        check("b2b_done_gap", 32'(done_e[1] - done_e[0]), 32'd10);
        check("b2b_first_latency", 32'(done_e[0] - acc_e[0]), 32'd9);
        for (int i = 0; i < 6; i++) begin
            logic [5:0][6:0] e42;
            e42 = mode_exp(8'd42, {D0, D0, D0, D0, D4, D2});
            check($sformatf("b2b_mid_ho%0d", i), 32'(mid_ho[i]), 32'(e42[i]));
        end
        check_ho("b2b_100", mode_exp(8'd100, {D0, D0, D0, D1, D0, D0}));

        // Reset in the 4th conversion cycle aborts without a done pulse.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        in_data  = 8'd123;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check_ho("abort", {6{BLK}});
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check_ho("abort_still_blank", {6{BLK}});
        send(8'd9, lat);
        check("after_abort_latency", 32'(lat), 32'd9);
        check_ho("after_abort_9", mode_exp(8'd9, {D0, D0, D0, D0, D0, D9}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
